// File: rtl/complex_mul_rs_if.sv
// complex_mul_rs_if: valid/ready stream bundle for complex_mul_rs.
//   Input side : in_valid/in_ready handshake, operands A and B, conj_b flag.
//   Output side: out_valid/out_ready handshake, res_real/res_imag, res_sat.
//   master modport drives operands and out_ready; slave modport is the multiplier.
interface complex_mul_rs_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 16
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  a_real;
  logic signed [IN_W-1:0]  a_imag;
  logic signed [IN_W-1:0]  b_real;
  logic signed [IN_W-1:0]  b_imag;
  logic                    conj_b;

  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] res_real;
  logic signed [OUT_W-1:0] res_imag;
  logic                    res_sat;

  modport master (
    output in_valid, a_real, a_imag, b_real, b_imag, conj_b, out_ready,
    input  in_ready, out_valid, res_real, res_imag, res_sat
  );

  modport slave (
    input  in_valid, a_real, a_imag, b_real, b_imag, conj_b, out_ready,
    output in_ready, out_valid, res_real, res_imag, res_sat
  );

endinterface : complex_mul_rs_if

// File: rtl/complex_mul_rs.sv
// complex_mul_rs: three-stage pipelined complex multiplier A*B or A*conj(B),
// with round-half-up scaling by 2^-SHIFT and saturation to OUT_W bits.
// The whole pipe advances together when the output register is empty or
// being consumed; bubbles are carried, not collapsed.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears valids and outputs
//   cm_if  : slave side of complex_mul_rs_if (operands in, results out)
// Constraints: 2 <= OUT_W <= 2*IN_W+1, 0 <= SHIFT <= 2*IN_W.
module complex_mul_rs #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  complex_mul_rs_if.slave  cm_if
);

  localparam int unsigned PW = 2 * IN_W;  // partial product width
  localparam int unsigned W2 = PW + 1;    // sum/difference width, cannot overflow
  localparam int unsigned W3 = W2 + 1;    // rounding width, headroom for the half-LSB add

  // Half an output LSB; zero when SHIFT is 0.
  localparam logic signed [W3-1:0] RND = W3'((W3'(1) << SHIFT) >> 1);

  localparam logic signed [W3-1:0] SAT_MAX = {{(W3-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [W3-1:0] SAT_MIN = {{(W3-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Pipe advance: output register empty or being drained this cycle.
  logic advance;

  // Stage 1 registers: partial products
  logic signed [PW-1:0] ac_q, bd_q, ad_q, bc_q;
  logic signed [PW-1:0] ac_d, bd_d, ad_d, bc_d;
  logic                 cj1_q;
  logic                 v1_q, v1_d;

  // Stage 2 registers: full-precision real/imag
  logic signed [W2-1:0] re2_q, im2_q;
  logic signed [W2-1:0] re2_d, im2_d;
  logic                 v2_q;

  // Stage 3 registers: scaled, saturated result
  logic signed [OUT_W-1:0] res_re_q, res_im_q;
  logic signed [OUT_W-1:0] res_re_d, res_im_d;
  logic                    res_sat_q, res_sat_d;
  logic                    sat_re, sat_im;
  logic                    out_valid_q;

  // Round half toward +inf, arithmetic shift, clamp to OUT_W; returns {sat, value}.
  function automatic logic [OUT_W:0] round_sat(input logic signed [W2-1:0] x);
    logic signed [W3-1:0] sum;
    logic signed [W3-1:0] y;
    logic [OUT_W-1:0]     v;
    logic                 s;
    sum = {x[W2-1], x} + RND;
    y   = sum >>> SHIFT;
    if (y > SAT_MAX) begin
      v = SAT_MAX[OUT_W-1:0];
      s = 1'b1;
    end else if (y < SAT_MIN) begin
      v = SAT_MIN[OUT_W-1:0];
      s = 1'b1;
    end else begin
      v = y[OUT_W-1:0];
      s = 1'b0;
    end
    return {s, v};
  endfunction

  assign advance        = !out_valid_q || cm_if.out_ready;
  assign cm_if.in_ready = advance;

  // Stage 1: four real products, operands sign-extended to full product width.
  always_comb begin
    ac_d = PW'(cm_if.a_real) * PW'(cm_if.b_real);
    bd_d = PW'(cm_if.a_imag) * PW'(cm_if.b_imag);
    ad_d = PW'(cm_if.a_real) * PW'(cm_if.b_imag);
    bc_d = PW'(cm_if.a_imag) * PW'(cm_if.b_real);
    v1_d = cm_if.in_valid && advance;
  end

  // Stage 2: combine products; conjugating B flips the sign of b_imag.
  always_comb begin
    logic signed [W2-1:0] ac_x, bd_x, ad_x, bc_x;
    ac_x = {ac_q[PW-1], ac_q};
    bd_x = {bd_q[PW-1], bd_q};
    ad_x = {ad_q[PW-1], ad_q};
    bc_x = {bc_q[PW-1], bc_q};
    if (cj1_q) begin
      re2_d = ac_x + bd_x;
      im2_d = bc_x - ad_x;
    end else begin
      re2_d = ac_x - bd_x;
      im2_d = ad_x + bc_x;
    end
  end

  // Stage 3: per-component scaling and saturation.
  always_comb begin
    {sat_re, res_re_d} = round_sat(re2_q);
    {sat_im, res_im_d} = round_sat(im2_q);
    res_sat_d          = sat_re | sat_im;
  end

  // Pipeline registers; everything holds while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_q        <= '0;
      bd_q        <= '0;
      ad_q        <= '0;
      bc_q        <= '0;
      cj1_q       <= 1'b0;
      v1_q        <= 1'b0;
      re2_q       <= '0;
      im2_q       <= '0;
      v2_q        <= 1'b0;
      res_re_q    <= '0;
      res_im_q    <= '0;
      res_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (advance) begin
      ac_q        <= ac_d;
      bd_q        <= bd_d;
      ad_q        <= ad_d;
      bc_q        <= bc_d;
      cj1_q       <= cm_if.conj_b;
      v1_q        <= v1_d;
      re2_q       <= re2_d;
      im2_q       <= im2_d;
      v2_q        <= v1_q;
      res_re_q    <= res_re_d;
      res_im_q    <= res_im_d;
      res_sat_q   <= res_sat_d;
      out_valid_q <= v2_q;
    end
  end

  assign cm_if.out_valid = out_valid_q;
  assign cm_if.res_real  = res_re_q;
  assign cm_if.res_imag  = res_im_q;
  assign cm_if.res_sat   = res_sat_q;

endmodule : complex_mul_rs

// File: tb/tb_complex_mul_rs.sv
// tb_complex_mul_rs: drives two multipliers in lockstep, one Q15 (OUT_W=16,
// SHIFT=15) and one full-precision (OUT_W=33, SHIFT=0), and checks them
// against constant vectors and an arithmetic reference model.
module tb_complex_mul_rs;

  localparam int unsigned IN_W = 16;
  localparam int unsigned OW_D = 16;
  localparam int unsigned SH_D = 15;
  localparam int unsigned OW_W = 33;
  localparam int unsigned SH_W = 0;

  localparam logic signed [15:0] MIN16 = 16'h8000;
  localparam logic signed [15:0] MAX16 = 16'h7FFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                   in_valid  = 1'b0;
  logic                   out_ready = 1'b1;
  logic                   conj_b    = 1'b0;
  logic signed [IN_W-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;

  complex_mul_rs_if #(.IN_W(IN_W), .OUT_W(OW_D)) ifd ();
  complex_mul_rs_if #(.IN_W(IN_W), .OUT_W(OW_W)) ifw ();

  assign ifd.in_valid  = in_valid;
  assign ifd.out_ready = out_ready;
  assign ifd.conj_b    = conj_b;
  assign ifd.a_real    = a_re;
  assign ifd.a_imag    = a_im;
  assign ifd.b_real    = b_re;
  assign ifd.b_imag    = b_im;
  assign ifw.in_valid  = in_valid;
  assign ifw.out_ready = out_ready;
  assign ifw.conj_b    = conj_b;
  assign ifw.a_real    = a_re;
  assign ifw.a_imag    = a_im;
  assign ifw.b_real    = b_re;
  assign ifw.b_imag    = b_im;

  complex_mul_rs #(.IN_W(IN_W), .OUT_W(OW_D), .SHIFT(SH_D)) dut_d (
    .clk(clk), .rst_n(rst_n), .cm_if(ifd)
  );
  complex_mul_rs #(.IN_W(IN_W), .OUT_W(OW_W), .SHIFT(SH_W)) dut_w (
    .clk(clk), .rst_n(rst_n), .cm_if(ifw)
  );

  typedef struct {
    logic signed [15:0] ar, ai, br, bi;
    logic               cj;
  } smp_t;

  typedef struct {
    logic signed [15:0] ar, ai, br, bi;
    logic               cj;
    longint             dre, dim;
    logic               dsat;
    longint             wre, wim;
    logic               wsat;
  } vec_t;

  smp_t qd[$];
  smp_t qw[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic                prev_stall [2];
  logic signed [63:0]  prev_re    [2];
  logic signed [63:0]  prev_im    [2];
  logic                prev_sat   [2];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: exact product, add half LSB, floor-divide, clamp.
  function automatic void rs_sat(input longint x, input int ow, input int sh,
                                 output longint y, output logic s);
    longint mx, mn;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    mn = -mx - 1;
    y  = x + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : longint'(0));
    y  = y >>> sh;
    s  = 1'b0;
    if (y > mx) begin y = mx; s = 1'b1; end
    else if (y < mn) begin y = mn; s = 1'b1; end
  endfunction

  function automatic void model(input smp_t s, input int ow, input int sh,
                                output longint re, output longint im, output logic sat);
    longint ar, ai, br, bi, xr, xi;
    logic   sr, si;
    ar = longint'(s.ar);
    ai = longint'(s.ai);
    br = longint'(s.br);
    bi = longint'(s.bi);
    // A*conj(B) is A*B with the sign of Im(B) flipped.
    if (s.cj) bi = -bi;
    xr = ar * br - ai * bi;
    xi = ar * bi + ai * br;
    rs_sat(xr, ow, sh, re, sr);
    rs_sat(xi, ow, sh, im, si);
    sat = sr | si;
  endfunction

  // Per-DUT scoreboard step, evaluated mid-cycle before the next rising edge.
  task automatic mon_step(input int k, input logic in_rdy, input logic out_v,
                          input logic signed [63:0] re, input logic signed [63:0] im,
                          input logic sat);
    smp_t   s;
    longint er, ei;
    logic   es;
    int     ow, sh;
    string  tag;
    ow  = (k == 0) ? int'(OW_D) : int'(OW_W);
    sh  = (k == 0) ? int'(SH_D) : int'(SH_W);
    tag = (k == 0) ? "q15" : "wide";
    check({tag, "_in_ready"}, 64'(in_rdy), 64'(!(out_v && !out_ready)));
    if (prev_stall[k]) begin
      check({tag, "_hold_valid"}, 64'(out_v), 64'(1));
      check({tag, "_hold_re"}, re, prev_re[k]);
      check({tag, "_hold_im"}, im, prev_im[k]);
      check({tag, "_hold_sat"}, 64'(sat), 64'(prev_sat[k]));
    end
    if (out_v && out_ready) begin
      if ((k == 0 && qd.size() == 0) || (k == 1 && qw.size() == 0)) begin
        check({tag, "_spurious_out"}, 64'(out_v), 64'(0));
      end else begin
        if (k == 0) s = qd.pop_front();
        else        s = qw.pop_front();
        model(s, ow, sh, er, ei, es);
        check({tag, "_model_re"}, re, er);
        check({tag, "_model_im"}, im, ei);
        check({tag, "_model_sat"}, 64'(sat), 64'(es));
      end
    end
    if (in_valid && in_rdy) begin
      s.ar = a_re; s.ai = a_im; s.br = b_re; s.bi = b_im; s.cj = conj_b;
      if (k == 0) qd.push_back(s);
      else        qw.push_back(s);
    end
    prev_stall[k] = out_v && !out_ready;
    prev_re[k]    = re;
    prev_im[k]    = im;
    prev_sat[k]   = sat;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_step(0, ifd.in_ready, ifd.out_valid, ifd.res_real, ifd.res_imag, ifd.res_sat);
      mon_step(1, ifw.in_ready, ifw.out_valid, ifw.res_real, ifw.res_imag, ifw.res_sat);
    end
  end

  function automatic logic signed [15:0] rnd16();
    case ($urandom_range(7))
      0:       return MIN16;
      1:       return MAX16;
      2:       return 16'(-$urandom_range(4));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive_rand();
    a_re   = rnd16();
    a_im   = rnd16();
    b_re   = rnd16();
    b_im   = rnd16();
    conj_b = 1'($urandom_range(1));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_d_valid"}, 64'(ifd.out_valid), 64'(0));
    check({tag, "_d_re"}, ifd.res_real, 64'(0));
    check({tag, "_d_im"}, ifd.res_imag, 64'(0));
    check({tag, "_d_sat"}, 64'(ifd.res_sat), 64'(0));
    check({tag, "_w_valid"}, 64'(ifw.out_valid), 64'(0));
    check({tag, "_w_re"}, ifw.res_real, 64'(0));
    check({tag, "_w_im"}, ifw.res_imag, 64'(0));
    check({tag, "_w_sat"}, 64'(ifw.res_sat), 64'(0));
  endtask

  // Random stream with given percentages of in_valid and out_ready.
  task automatic run_random(input int n, input int pv, input int pr);
    int   sent;
    int   cyc;
    logic acc;
    sent = 0;
    cyc  = 0;
    @(posedge clk); #1;
    drive_rand();
    in_valid  = ($urandom_range(99) < pv);
    out_ready = ($urandom_range(99) < pr);
    while (sent < n && cyc < 20000) begin
      @(negedge clk);
      acc = in_valid && ifd.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) sent++;
      if (acc || !in_valid) begin
        drive_rand();
        in_valid = (sent < n) && ($urandom_range(99) < pv);
      end
      out_ready = ($urandom_range(99) < pr);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("random_sent", 64'(sent), 64'(n));
    repeat (8) @(posedge clk);
    @(negedge clk); #1;
    check("drain_q15", 64'(qd.size()), 64'(0));
    check("drain_wide", 64'(qw.size()), 64'(0));
  endtask

  vec_t vt[10];

  initial begin
    int lat;

    vt[0] = '{16'sd3, 16'sd4, 16'sd1, 16'sd2, 1'b0, 0, 0, 1'b0, -5, 10, 1'b0};
    vt[1] = '{16'sd3, 16'sd4, 16'sd1, 16'sd2, 1'b1, 0, 0, 1'b0, 11, -2, 1'b0};
    vt[2] = '{16'sd1, 16'sd0, 16'sd16384, 16'sd0, 1'b0, 1, 0, 1'b0, 16384, 0, 1'b0};
    vt[3] = '{16'sd1, 16'sd0, 16'sd16383, 16'sd0, 1'b0, 0, 0, 1'b0, 16383, 0, 1'b0};
    vt[4] = '{16'sd16384, 16'sd0, 16'sd16384, 16'sd0, 1'b0, 8192, 0, 1'b0, 268435456, 0, 1'b0};
    vt[5] = '{MIN16, MIN16, MIN16, MIN16, 1'b0, 0, 32767, 1'b1, 0, 64'sd2147483648, 1'b0};
    vt[6] = '{MIN16, MIN16, MIN16, MIN16, 1'b1, 32767, 0, 1'b1, 64'sd2147483648, 0, 1'b0};
    vt[7] = '{-16'sd1, 16'sd0, 16'sd16384, 16'sd0, 1'b0, 0, 0, 1'b0, -16384, 0, 1'b0};
    vt[8] = '{-16'sd1, 16'sd0, 16'sd16385, 16'sd0, 1'b0, -1, 0, 1'b0, -16385, 0, 1'b0};
    vt[9] = '{MIN16, MAX16, MAX16, MIN16, 1'b1, -32768, -2, 1'b1, -64'sd2147418112, -65535, 1'b0};

    prev_stall[0] = 1'b0;
    prev_stall[1] = 1'b0;

    // Reset state
    #3;
    check_zero_outputs("reset");
    check("reset_in_ready", 64'(ifd.in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Constant vectors, one at a time, latency measured from acceptance.
    foreach (vt[i]) begin
      @(posedge clk); #1;
      a_re = vt[i].ar; a_im = vt[i].ai; b_re = vt[i].br; b_im = vt[i].bi;
      conj_b = vt[i].cj; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!ifd.out_valid && lat < 10);
      #1;
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(3));
      check($sformatf("vec%0d_w_valid", i), 64'(ifw.out_valid), 64'(1));
      check($sformatf("vec%0d_d_re", i), ifd.res_real, vt[i].dre);
      check($sformatf("vec%0d_d_im", i), ifd.res_imag, vt[i].dim);
      check($sformatf("vec%0d_d_sat", i), 64'(ifd.res_sat), 64'(vt[i].dsat));
      check($sformatf("vec%0d_w_re", i), ifw.res_real, vt[i].wre);
      check($sformatf("vec%0d_w_im", i), ifw.res_imag, vt[i].wim);
      check($sformatf("vec%0d_w_sat", i), 64'(ifw.res_sat), 64'(vt[i].wsat));
    end

    // Backpressure: continuous input, toggling out_ready.
    run_random(20, 100, 50);
    // Mixed bubbles and stalls.
    run_random(300, 60, 60);

    // Back-to-back: full pipe, one output per cycle, in_ready stays high.
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive_rand();
    for (int c = 0; c < 13; c++) begin
      @(negedge clk); #1;
      if (c >= 3) begin
        check($sformatf("b2b%0d_valid", c), 64'(ifd.out_valid), 64'(1));
        check($sformatf("b2b%0d_in_ready", c), 64'(ifd.in_ready), 64'(1));
      end
      @(posedge clk); #1;
      drive_rand();
    end
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    check("b2b_drain_q15", 64'(qd.size()), 64'(0));
    check("b2b_drain_wide", 64'(qw.size()), 64'(0));

    // Reset with three samples in flight behind a stalled output.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive_rand();
    repeat (3) begin
      @(posedge clk); #1;
      drive_rand();
    end
    in_valid = 1'b0;
    check("inflight_valid", 64'(ifd.out_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    qd.delete();
    qw.delete();
    prev_stall[0] = 1'b0;
    prev_stall[1] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check($sformatf("post_reset%0d_d_valid", c), 64'(ifd.out_valid), 64'(0));
      check($sformatf("post_reset%0d_w_valid", c), 64'(ifw.out_valid), 64'(0));
    end

    // Pipe still works after reset.
    run_random(30, 80, 70);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_complex_mul_rs

// File: doc/complex_mul_rs.md
Name: complex_mul_rs

Overview:
Parametrised, fully pipelined complex multiplier with optional per-sample conjugation of operand B, round-half-up scaling, saturation to a programmable output width, and valid/ready backpressure. It is the next-generation datapath primitive for the signal-processing chain, replacing the fixed-width free-running multiplier in mixers, FFT twiddle stages and correlators. Stall-capable, so it can sit directly behind FIFOs and ahead of bursty consumers.

Parameters:
IN_W, 16, signed two's-complement width of each input component
OUT_W, 16, signed width of each output component; constraint 2 <= OUT_W <= 2*IN_W+1
SHIFT, 15, arithmetic right shift applied after rounding (Q-format scaling); constraint 0 <= SHIFT <= 2*IN_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept input this cycle
a_real  in  IN_W  operand A real, signed
a_imag  in  IN_W  operand A imaginary, signed
b_real  in  IN_W  operand B real, signed
b_imag  in  IN_W  operand B imaginary, signed
conj_b  in  1  1: compute A*conj(B) for this sample; sampled with the input
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output
res_real  out  OUT_W  result real, signed
res_imag  out  OUT_W  result imaginary, signed
res_sat  out  1  1 if either component of this sample was saturated

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. While rst_n=0, all stage valid bits, res_real, res_imag, res_sat and out_valid are 0. Reset asserted mid-operation discards all in-flight samples. No output is produced for samples accepted before reset.
- Handshake: advance = !out_valid || out_ready. in_ready = advance (combinational). An input is accepted on a cycle where in_valid && in_ready. An output is consumed on a cycle where out_valid && out_ready.
- While advance=0, all pipeline registers hold, including data and valid bits. Outputs are stable while out_valid && !out_ready. Bubbles are not collapsed; the whole pipe shifts together.
- Latency is 3 advancing cycles from acceptance to out_valid. Throughput is 1 sample/cycle with out_ready held at 1.
- Stage 1 (on advance): register ac=a_real*b_real, bd=a_imag*b_imag, ad=a_real*b_imag, bc=a_imag*b_real, each 2*IN_W signed. Also register conj_b and valid=in_valid&&in_ready.
- Stage 2: work at W2=2*IN_W+1 bits, sign-extended, with no internal overflow.
  - conj=0: re=ac-bd, im=ad+bc.
  - conj=1: re=ac+bd, im=bc-ad.
- Stage 3, per component x:
  - y = (x + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT. Rounding is half toward +inf, computed at W2+1 bits.
  - If y > 2^(OUT_W-1)-1, output the max value. If y < -2^(OUT_W-1), output the min value. Otherwise output y truncated to OUT_W.
  - res_sat = sat_re | sat_im. Register res_real, res_imag, res_sat and out_valid.
- out_valid=0 samples may carry stale data. out_valid never asserts without a corresponding accepted input.
- Simultaneous accept and consume with the pipe full: both occur in the same cycle, with no loss or duplication.
- Full-scale corner: (-2^(IN_W-1))^2 terms are representable in W2 and are handled correctly.

Test Plan:
- IN_W=16, OUT_W=33, SHIFT=0, out_ready=1: A=(3,4), B=(1,2), conj_b=0 -> res=(-5,10), res_sat=0, out_valid exactly 3 cycles after acceptance. Same operands with conj_b=1 -> res=(11,-2).
- Defaults (Q15 rounding): A=(1,0), B=(16384,0) -> res_real=1. A=(1,0), B=(16383,0) -> res_real=0. A=(16384,0), B=(16384,0) -> res_real=8192.
- Defaults (saturation): A=B=(-32768,-32768), conj_b=0 -> res_real=0, res_imag=32767, res_sat=1. Same operands with conj_b=1 -> res_real=32767 (2^31>>15 saturates), res_imag=0, res_sat=1.
- Backpressure: stream 20 random samples with in_valid=1 and out_ready toggling pseudo-randomly -> output sequence equals the reference model in order, with no drops or duplicates. in_ready=0 exactly when out_valid=1 and out_ready=0. Outputs stay stable during stalls.
- Reset mid-stream: assert rst_n=0 with 3 samples in flight -> out_valid, res_real, res_imag and res_sat go to 0 immediately (asynchronously). After release with in_valid=0, no output appears for 5 cycles.
- Back-to-back accept/consume: pipe full, out_ready=1, in_valid=1 continuously for 10 cycles -> one output per cycle, in_ready held at 1.
